// File: rtl/nandn_pkg.sv
// Shared definitions for the pipelined NAND-family reduction: mode encodings
// and elaboration-time geometry helpers.
package nandn_pkg;

  typedef enum logic [1:0] {
    MODE_NAND = 2'd0,
    MODE_AND  = 2'd1,
    MODE_NOR  = 2'd2,
    MODE_OR   = 2'd3
  } mode_e;

  // Tree depth: smallest L >= 1 with FANIN**L >= WIDTH.
  function automatic int unsigned calc_levels(input int unsigned width,
                                              input int unsigned fanin);
    int unsigned lv;
    int unsigned span;
    lv   = 1;
    span = fanin;
    while (span < width) begin
      span = span * fanin;
      lv++;
    end
    return lv;
  endfunction

  function automatic int unsigned pad_width(input int unsigned fanin,
                                            input int unsigned levels);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < levels; k++) p = p * fanin;
    return p;
  endfunction

endpackage

// File: rtl/nandn_stage.sv
// One pipeline level: AND-reduces FANIN-wide groups of its input and registers
// the result with valid and inv_out, under a combinational ready chain.
module nandn_stage
  import nandn_pkg::*;
#(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned FANIN = 3
) (
  input  logic                  ck,
  input  logic                  nrst,
  input  logic [IN_W-1:0]       d_i,
  input  logic                  inv_i,
  input  logic                  valid_i,
  input  logic                  ready_i,
  output logic                  ready_o,
  output logic [IN_W/FANIN-1:0] d_o,
  output logic                  inv_o,
  output logic                  valid_o
);

  localparam int unsigned OUT_W = IN_W / FANIN;

  logic [OUT_W-1:0] d_d;
  logic [OUT_W-1:0] d_q;
  logic             inv_q;
  logic             v_q;

  always_comb begin
    d_d = '0;
    for (int unsigned g = 0; g < OUT_W; g++) d_d[g] = &d_i[g*FANIN +: FANIN];
  end

  assign ready_o = ~v_q | ready_i;

  // Payload only loads with a real beat so bubbles leave held data untouched.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      v_q   <= 1'b0;
      d_q   <= '0;
      inv_q <= 1'b0;
    end else if (ready_o) begin
      v_q <= valid_i;
      if (valid_i) begin
        d_q   <= d_d;
        inv_q <= inv_i;
      end
    end
  end

  assign d_o     = d_q;
  assign inv_o   = inv_q;
  assign valid_o = v_q;

endmodule

// File: rtl/nandn_pipe.sv
// Pipelined N-input NAND/AND/NOR/OR reduction with valid/ready flow control;
// conditions the operand, chains LEVELS stages, and XORs the final bit.
module nandn_pipe
  import nandn_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned FANIN = 3
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       mode,
  input  logic             i_valid,
  output logic             i_ready,
  output logic             q,
  output logic             q_valid,
  input  logic             q_ready
);

  localparam int unsigned LEVELS = calc_levels(WIDTH, FANIN);
  localparam int unsigned PAD_W  = pad_width(FANIN, LEVELS);

  if (WIDTH < 2 || WIDTH > 64 || FANIN < 2 || FANIN > 4) begin : g_bad_param
    $fatal(1, "nandn_pipe: WIDTH must be 2..64 and FANIN 2..4");
  end

  logic [PAD_W-1:0] cond;
  logic             inv_in;

  // Pad with the AND identity; NOR/OR become AND of the inverted operand.
  always_comb begin
    cond            = '1;
    cond[WIDTH-1:0] = mode[1] ? ~i : i;
  end

  assign inv_in = ~(mode[1] ^ mode[0]);

  for (genvar k = 0; k < LEVELS; k++) begin : g_lv
    localparam int unsigned IN_W = pad_width(FANIN, LEVELS - k);

    logic [IN_W-1:0]       d_in;
    logic [IN_W/FANIN-1:0] d_out;
    logic                  inv_src;
    logic                  v_src;
    logic                  rdy_dn;
    logic                  inv_out;
    logic                  v_out;
    logic                  rdy_out;

    if (k == 0) begin : g_head
      assign d_in    = cond;
      assign inv_src = inv_in;
      assign v_src   = i_valid;
    end else begin : g_body
      assign d_in    = g_lv[k-1].d_out;
      assign inv_src = g_lv[k-1].inv_out;
      assign v_src   = g_lv[k-1].v_out;
    end

    if (k == LEVELS - 1) begin : g_tail
      assign rdy_dn = q_ready;
    end else begin : g_next
      assign rdy_dn = g_lv[k+1].rdy_out;
    end

    nandn_stage #(
      .IN_W  (IN_W),
      .FANIN (FANIN)
    ) u_stage (
      .ck      (ck),
      .nrst    (nrst),
      .d_i     (d_in),
      .inv_i   (inv_src),
      .valid_i (v_src),
      .ready_i (rdy_dn),
      .ready_o (rdy_out),
      .d_o     (d_out),
      .inv_o   (inv_out),
      .valid_o (v_out)
    );
  end

  assign i_ready = g_lv[0].rdy_out;
  assign q_valid = g_lv[LEVELS-1].v_out;
  assign q       = g_lv[LEVELS-1].d_out[0] ^ g_lv[LEVELS-1].inv_out;

endmodule

// File: tb/tb_nandn_pipe.sv
// Self-checking bench for nandn_pipe: table vectors and random beats through a
// scoreboard on a 9/3 instance, plus latency/padding checks on a 10/3 instance.
module tb_nandn_pipe;
  import nandn_pkg::*;

  logic       ck;
  logic       nrst;
  logic [8:0] a_i;
  logic [1:0] a_mode;
  logic       a_valid, a_ready, a_q, a_qv, a_qr;
  logic [9:0] b_i;
  logic [1:0] b_mode;
  logic       b_valid, b_ready, b_q, b_qv, b_qr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_dlv = 0;
  logic sb[$];
  int   dlv_cyc[$];

  nandn_pipe #(.WIDTH(9), .FANIN(3)) dut9 (
    .ck(ck), .nrst(nrst), .i(a_i), .mode(a_mode), .i_valid(a_valid),
    .i_ready(a_ready), .q(a_q), .q_valid(a_qv), .q_ready(a_qr)
  );

  nandn_pipe #(.WIDTH(10), .FANIN(3)) dut10 (
    .ck(ck), .nrst(nrst), .i(b_i), .mode(b_mode), .i_valid(b_valid),
    .i_ready(b_ready), .q(b_q), .q_valid(b_qv), .q_ready(b_qr)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;
  always @(posedge ck) cyc++;

  typedef struct {
    logic [8:0] i;
    logic [1:0] m;
    logic       e;
  } vec_t;

  function automatic logic model(input logic [8:0] v, input logic [1:0] m);
    case (m)
      MODE_NAND: return ~&v;
      MODE_AND:  return &v;
      MODE_NOR:  return ~|v;
      default:   return |v;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Deliveries are decided by the levels held between edges, sampled mid-cycle.
  always @(negedge ck) begin
    if (nrst && a_qv && a_qr) begin
      n_dlv++;
      dlv_cyc.push_back(cyc);
      if (sb.size() == 0) check("unexpected_out", {31'd0, a_q}, 32'hDEAD);
      else check("sb_q", {31'd0, a_q}, {31'd0, sb.pop_front()});
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [8:0] v, input logic [1:0] m, input logic e);
    int n;
    n = 0;
    a_i = v; a_mode = m; a_valid = 1'b1;
    forever begin
      @(negedge ck);
      if (a_ready) begin
        sb.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge ck); #1;
    a_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    a_qr = 1'b1;
    while (sb.size() != 0 && n < 30) begin
      @(posedge ck); #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic pad_beat(input logic [9:0] v, input logic [1:0] m, input logic e, input string tag);
    b_i = v; b_mode = m; b_valid = 1'b1;
    @(negedge ck); check({tag, "_acc"}, {31'd0, b_ready}, 1);
    @(posedge ck); #1; b_valid = 1'b0;
    check({tag, "_lat1"}, {31'd0, b_qv}, 0);
    @(posedge ck); #1; check({tag, "_lat2"}, {31'd0, b_qv}, 0);
    @(posedge ck); #1;
    check({tag, "_lat3_v"}, {31'd0, b_qv}, 1);
    check({tag, "_lat3_q"}, {31'd0, b_q}, {31'd0, e});
    @(posedge ck); #1; check({tag, "_gone"}, {31'd0, b_qv}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int   base;
    bit   rand_done;
    logic [8:0] rv;
    logic [1:0] rm;

    tbl[0]  = '{9'h1FF, MODE_NAND, 1'b0};
    tbl[1]  = '{9'h1FE, MODE_NAND, 1'b1};
    tbl[2]  = '{9'h000, MODE_NAND, 1'b1};
    tbl[3]  = '{9'h000, MODE_AND,  1'b0};
    tbl[4]  = '{9'h000, MODE_NOR,  1'b1};
    tbl[5]  = '{9'h000, MODE_OR,   1'b0};
    tbl[6]  = '{9'h1FF, MODE_AND,  1'b1};
    tbl[7]  = '{9'h1FF, MODE_NOR,  1'b0};
    tbl[8]  = '{9'h1FF, MODE_OR,   1'b1};
    tbl[9]  = '{9'h100, MODE_OR,   1'b1};
    tbl[10] = '{9'h100, MODE_NOR,  1'b0};
    tbl[11] = '{9'h0FF, MODE_AND,  1'b0};

    nrst = 1'b0;
    a_i = 9'h1FF; a_mode = MODE_NAND; a_valid = 1'b1; a_qr = 1'b1;
    b_i = '0; b_mode = MODE_AND; b_valid = 1'b0; b_qr = 1'b1;

    // Reset holds everything empty even with traffic offered.
    #3;
    check("rst_q", {31'd0, a_q}, 0);
    check("rst_qv", {31'd0, a_qv}, 0);
    check("rst_irdy", {31'd0, a_ready}, 1);
    repeat (2) @(negedge ck);
    check("rst_qv_held", {31'd0, a_qv}, 0);
    @(posedge ck); #1;
    a_valid = 1'b0;
    nrst = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    check("rst_nothing_accepted", {31'd0, a_qv}, 0);

    // Single beat latency: visible after the edge following acceptance.
    a_i = tbl[0].i; a_mode = tbl[0].m; a_valid = 1'b1;
    @(negedge ck);
    check("lat_acc", {31'd0, a_ready}, 1);
    sb.push_back(tbl[0].e);
    @(posedge ck); #1; a_valid = 1'b0;
    check("lat_early", {31'd0, a_qv}, 0);
    @(posedge ck); #1;
    check("lat_v", {31'd0, a_qv}, 1);
    check("lat_q", {31'd0, a_q}, 0);
    drain();

    for (int k = 1; k < 12; k++) begin
      send(tbl[k].i, tbl[k].m, tbl[k].e);
      repeat (k % 2) @(posedge ck);
      #1;
    end
    drain();

    // Back-to-back modes with no bubbles.
    dlv_cyc.delete();
    for (int m = 0; m < 4; m++) send(9'h000, m[1:0], m[0] ? 1'b0 : 1'b1);
    repeat (4) @(posedge ck);
    #1;
    check("b2b_count", dlv_cyc.size(), 4);
    for (int k = 1; k < 4; k++)
      if (k < dlv_cyc.size()) check("b2b_gap", dlv_cyc[k] - dlv_cyc[k-1], 1);
    drain();

    // Backpressure: capacity 2, recovery is combinational.
    base = n_dlv;
    a_qr = 1'b0;
    send(9'h000, MODE_NAND, 1'b1);
    send(9'h000, MODE_AND,  1'b0);
    check("bp_full_irdy", {31'd0, a_ready}, 0);
    check("bp_full_qv", {31'd0, a_qv}, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge ck); #1;
      check("bp_hold_irdy", {31'd0, a_ready}, 0);
    end
    a_qr = 1'b1;
    #1;
    check("bp_recover", {31'd0, a_ready}, 1);
    send(9'h1FF, MODE_NAND, 1'b0);
    send(9'h1FF, MODE_AND,  1'b1);
    send(9'h000, MODE_NOR,  1'b1);
    send(9'h1FF, MODE_NOR,  1'b0);
    drain();
    check("bp_count", n_dlv - base, 6);

    // Random beats against random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          rv = 9'($urandom);
          if (k % 3 == 0) rv = 9'h1FF;
          rm = 2'($urandom_range(0, 3));
          send(rv, rm, model(rv, rm));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge ck); #1;
          a_qr = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Asynchronous reset mid-stream flushes in-flight beats.
    a_qr = 1'b0;
    send(9'h1FF, MODE_AND, 1'b1);
    send(9'h000, MODE_OR,  1'b0);
    check("mrst_pre_qv", {31'd0, a_qv}, 1);
    #1 nrst = 1'b0;
    #1;
    check("mrst_qv", {31'd0, a_qv}, 0);
    check("mrst_q", {31'd0, a_q}, 0);
    check("mrst_irdy", {31'd0, a_ready}, 1);
    sb.delete();
    #1 nrst = 1'b1;
    base = n_dlv;
    a_qr = 1'b1;
    repeat (5) @(posedge ck);
    #1;
    check("mrst_no_stale", n_dlv - base, 0);

    // Padding on the 10-bit, three-level instance.
    pad_beat(10'h3FF, MODE_AND, 1'b1, "pad_ones");
    pad_beat(10'h1FF, MODE_AND, 1'b0, "pad_msb0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
